// File: rtl/myproject_mul_16s_13s_rr_share_pkg.sv
// Shared definitions for lane-sharing controllers.
//
// Contents:
//   MAX_REQ / MAX_IDX_W : largest requester count the helpers support
//   rr_pick_t           : result of a round-robin scan (found flag + index)
//   own_width()         : owner-index width for a given requester count
//   rr_first()          : first set request bit at or after a pointer, wrapping
package myproject_mul_16s_13s_rr_share_pkg;

  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // Width of an owner tag. A single requester still needs one bit.
  function automatic int own_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scan req starting at ptr, wrapping at n (n need not be a power of two).
  // The caller guarantees ptr < n and n <= MAX_REQ.
  function automatic rr_pick_t rr_first(
    input logic [MAX_REQ-1:0]   req,
    input logic [MAX_IDX_W-1:0] ptr,
    input int                   n
  );
    rr_pick_t             res;
    int                   pos;
    logic [MAX_IDX_W-1:0] pos_idx;
    res = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= n) pos = pos - n;
      pos_idx = MAX_IDX_W'(pos);
      if ((k < n) && !res.found && req[pos_idx]) begin
        res.found = 1'b1;
        res.idx   = pos_idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/myproject_mul_16s_13s_rr_share_mul.sv
// Combinational full-precision signed multiplier shared by all requesters.
//
// Ports:
//   a : signed operand, A_W bits
//   b : signed operand, B_W bits
//   p : signed product, P_W = A_W + B_W bits (never overflows)
module myproject_mul_mul_16s_13s_29_1_1 #(
  parameter int A_W = 16,
  parameter int B_W = 13,
  parameter int P_W = 29
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [P_W-1:0] p
);

  // Both operands are signed, so they are sign-extended to P_W before the
  // multiply and the full product is kept.
  assign p = a * b;

endmodule

// File: rtl/myproject_mul_16s_13s_rr_share.sv
// Round-robin arbiter and two-stage pipeline that shares one signed
// multiplier among N_REQ requesters.
//
// Ports:
//   ap_clk, ap_rst_n : clock (rising edge), async active-low reset
//   req_valid/ready  : per-requester operand handshake (ready is one-hot)
//   req_a, req_b     : flattened operands, requester i at [i*W +: W]
//   rsp_valid/ready  : per-requester result handshake (valid is one-hot)
//   rsp_p            : product bus shared by all requesters
//   busy             : any pipeline stage holds data
module myproject_mul_16s_13s_rr_share
  import myproject_mul_16s_13s_rr_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int A_W   = 16,
  parameter int B_W   = 13,
  parameter int P_W   = 29
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic [N_REQ-1:0]     rsp_valid,
  input  logic [N_REQ-1:0]     rsp_ready,
  output logic [P_W-1:0]       rsp_p,
  output logic                 busy
);

  localparam int OWN_W = own_width(N_REQ);

  // Pipeline state
  logic                  s1_vld;
  logic signed [A_W-1:0] s1_a;
  logic signed [B_W-1:0] s1_b;
  logic [OWN_W-1:0]      s1_own;
  logic                  s2_vld;
  logic signed [P_W-1:0] s2_p;
  logic [OWN_W-1:0]      s2_own;
  logic [OWN_W-1:0]      rr_ptr;
  // Low for the first cycle after reset release so req_ready is quiet
  // while the block is held in reset.
  logic                  arb_en;

  // Control
  logic                  s2_adv;
  logic                  s1_adv;
  logic                  grant;
  logic [OWN_W-1:0]      win;
  logic signed [A_W-1:0] sel_a;
  logic signed [B_W-1:0] sel_b;
  logic signed [P_W-1:0] mul_p;
  logic [OWN_W-1:0]      ptr_next;
  rr_pick_t              pick;
  logic [MAX_REQ-1:0]    req_ext;

  assign s2_adv = !s2_vld || rsp_ready[s2_own];
  assign s1_adv = !s1_vld || s2_adv;

  // Arbitration and operand selection
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    req_ext = '0;
    sel_a   = '0;
    sel_b   = '0;
    req_ready = '0;
    req_ext[N_REQ-1:0] = req_valid;
    pick  = rr_first(req_ext, MAX_IDX_W'(rr_ptr), N_REQ);
    win   = OWN_W'(pick.idx);
    grant = pick.found && s1_adv && arb_en;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == OWN_W'(i)) begin
        sel_a = req_a[i*A_W +: A_W];
        sel_b = req_b[i*B_W +: B_W];
        req_ready[i] = grant;
      end
    end
  end

  // Pointer moves past the winner, wrapping at N_REQ (not a power of two
  // in general).
  always_comb begin
    ptr_next = rr_ptr;
    if (grant) begin
      if (int'(win) == N_REQ - 1) ptr_next = '0;
      else                        ptr_next = win + OWN_W'(1);
    end
  end

  myproject_mul_mul_16s_13s_29_1_1 #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_mul (
    .a (s1_a),
    .b (s1_b),
    .p (mul_p)
  );

  // NOTE: state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  // Data registers are reset along with the valid bits, so rsp_p and the
  // owner tags read as zero out of reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      arb_en <= 1'b0;
      rr_ptr <= '0;
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_own <= '0;
      s2_vld <= 1'b0;
      s2_p   <= '0;
      s2_own <= '0;
    end else begin
      arb_en <= 1'b1;
      rr_ptr <= ptr_next;
      // S2 drains and S1 moves forward on the same edge; a new operand may
      // enter S1 in that edge too, so there is no bubble.
      if (s2_adv) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_p   <= mul_p;
          s2_own <= s1_own;
        end
      end
      if (s1_adv) begin
        s1_vld <= grant;
        if (grant) begin
          s1_a   <= sel_a;
          s1_b   <= sel_b;
          s1_own <= win;
        end
      end
    end
  end

  // Response routing: only the owner sees valid; rsp_p holds while stalled.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = s2_vld && (s2_own == OWN_W'(i));
    end
  end

  assign rsp_p = s2_p;
  assign busy  = s1_vld || s2_vld;

endmodule
